serial_addsub: RTL and testbench

- Parametrised, digit-serial add/subtract unit for the RISC-V sample datapath.
- Generalises the 1-bit full-adder cell into a multi-cycle WIDTH-bit adder/subtractor.
- Each cycle it processes DIGIT bits through a chain of DIGIT full-adder slices and registers the carry between digits.
- Used where area matters more than latency, e.g. a low-cost ALU option or an address-offset unit, with a start/ready/valid handshake.

---
 rtl/serial_addsub.sv | 128 ++++++++++++
 tb/tb_serial_addsub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT full-adder slices per cycle,
// carry registered between digits, start/ready/valid handshake.
module serial_addsub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_shift;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIGIT-1:0] dsum;
   logic [DIGIT:0]   c;

   // Ripple chain over the low digit of the operand shift registers.
   always_comb begin
      c    = '0;
      dsum = '0;
      c[0] = cy_q;
      for (int i = 0; i < DIGIT; i++) begin
         dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
         c[i + 1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
      end
   end

   assign res_shift = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = sub_i ? ~b_i : b_i;
               cy_d    = sub_i;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            res_d = res_shift;
            cy_d  = c[DIGIT];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // c[DIGIT-1] is the carry into bit WIDTH-1 on the MSB digit
               state_d = S_DONE;
               cnt_d   = '0;
               sum_d   = res_shift;
               carry_d = c[DIGIT];
               ovf_d   = c[DIGIT] ^ c[DIGIT - 1];
               zero_d  = (res_shift == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign ready_o = (state_q != S_RUN);
   assign valid_o = (state_q == S_DONE);
   assign sum_o   = sum_q;
   assign carry_o = carry_q;
   assign ovf_o   = ovf_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector and reference-model bench for serial_addsub (32/4, 8/1, 8/8).
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, sub = 1'b0;
   logic [31:0] a_in = '0, b_in = '0, sum;
   logic        ready, valid, carry, ovf, zero;

   logic        start_s = 1'b0, start_p = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, sum_s, sum_p;
   logic        ready_s, valid_s, carry_s, ovf_s, zero_s;
   logic        ready_p, valid_p, carry_p, ovf_p, zero_p;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a_in), .b_i(b_in),
      .ready_o(ready), .valid_o(valid), .sum_o(sum), .carry_o(carry), .ovf_o(ovf), .zero_o(zero));

   serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_s (
      .clk_i(clk), .rst_i(rst), .start_i(start_s), .sub_i(sub8), .a_i(a8), .b_i(b8),
      .ready_o(ready_s), .valid_o(valid_s), .sum_o(sum_s), .carry_o(carry_s), .ovf_o(ovf_s),
      .zero_o(zero_s));

   serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_p (
      .clk_i(clk), .rst_i(rst), .start_i(start_p), .sub_i(sub8), .a_i(a8), .b_i(b8),
      .ready_o(ready_p), .valid_o(valid_p), .sum_o(sum_p), .carry_o(carry_p), .ovf_o(ovf_p),
      .zero_o(zero_p));

   typedef struct {
      logic        s;
      logic [31:0] a, b, sum;
      logic        c, v, z;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      sub = s; a_in = a; b_in = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      sub = ~s; a_in = $urandom; b_in = $urandom;
   endtask

   task automatic wait_valid(output int lat, output logic rdy_low);
      lat = 0;
      rdy_low = 1'b1;
      while (lat < 40) begin
         @(negedge clk);
         if (valid) break;
         if (ready) rdy_low = 1'b0;
         lat++;
      end
   endtask

   function automatic logic [33:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      logic        ov;
      r  = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      ov = s ? ((a[31] != b[31]) && (r[31] != a[31])) : ((a[31] == b[31]) && (r[31] != a[31]));
      return {r[32], ov, r[31:0]};
   endfunction

   initial begin
      int          lat, lat2;
      logic        rl, ok;
      logic        rs;
      logic [31:0] ra, rb;
      logic [33:0] m;

      vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'd9,         32'd9,         32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

      #3;
      chk("rst_ready", ready, 1);
      chk("rst_valid", valid, 0);
      chk("rst_outs", {sum, carry, ovf, zero}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].s, vecs[i].a, vecs[i].b);
         wait_valid(lat, rl);
         chk($sformatf("v%0d_lat", i), lat, 8);
         chk($sformatf("v%0d_ready_low", i), rl, 1);
         chk($sformatf("v%0d_sum", i), sum, vecs[i].sum);
         chk($sformatf("v%0d_carry", i), carry, vecs[i].c);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].v);
         chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
         @(negedge clk);
         chk($sformatf("v%0d_pulse_hold", i), {valid, ready, sum}, {1'b0, 1'b1, vecs[i].sum});
      end

      // back-to-back: start held through DONE, new operands accepted there
      @(negedge clk);
      sub = 1'b0; a_in = 32'd1; b_in = 32'd1; start = 1'b1;
      @(posedge clk);
      wait_valid(lat, rl);
      chk("b2b_first_sum", sum, 2);
      a_in = 32'd3; b_in = 32'd4;
      @(posedge clk);
      #1 start = 1'b0;
      lat2 = 0;
      ok = 1'b1;
      while (lat2 < 40) begin
         @(negedge clk);
         if (valid) break;
         if (sum !== 32'd2) ok = 1'b0;
         lat2++;
      end
      chk("b2b_lat", lat2, 8);
      chk("b2b_hold", ok, 1);
      chk("b2b_sum", sum, 7);

      // start pulsed mid-RUN with different operands is ignored
      issue(1'b0, 32'd10, 32'd20);
      repeat (3) @(negedge clk);
      a_in = 32'd99; b_in = 32'd1; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(lat, rl);
      chk("busy_lat", lat + 4, 8);
      chk("busy_sum", sum, 30);

      // asynchronous reset mid-RUN aborts without a pulse
      issue(1'b0, 32'h7FFF_FFFF, 32'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_ready", ready, 1);
      chk("abort_valid", valid, 0);
      chk("abort_outs", {sum, carry, ovf, zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (valid) ok = 1'b0;
      end
      chk("abort_no_pulse", ok, 1);

      // DIGIT=1 and DIGIT=WIDTH variants
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; start_s = 1'b1;
      @(posedge clk);
      #1 start_s = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (valid_s) break;
         lat++;
      end
      chk("d1_lat", lat, 8);
      chk("d1_result", {sum_s, carry_s, ovf_s, zero_s}, {8'hFF, 3'b000});

      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; start_p = 1'b1;
      @(posedge clk);
      #1 start_p = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (valid_p) break;
         lat++;
      end
      chk("dw_lat", lat, 1);
      chk("dw_result", {sum_p, carry_p, ovf_p, zero_p}, {8'h00, 3'b111});

      // random operations against the arithmetic reference
      for (int k = 0; k < 1000; k++) begin
         rs = 1'($urandom_range(1, 0));
         ra = $urandom;
         rb = ($urandom_range(3, 0) == 0) ? ra : 32'($urandom);
         if ($urandom_range(7, 0) == 0) ra = 32'h8000_0000;
         m = model(rs, ra, rb);
         issue(rs, ra, rb);
         wait_valid(lat, rl);
         chk($sformatf("rnd%0d", k), {lat[7:0], carry, ovf, sum}, {8'd8, m});
         chk($sformatf("rnd%0d_zero", k), zero, (m[31:0] == 32'd0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
